instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the accumulator CPU. It steps each instruction through FETCH,
//  DECODE, EXEC, MEM and WB. It drives the memory request handshake, IR/PC/SP strobes and the phase
//  enables that qualify the decoder's control lines (ALU, LOAD, STORE, STACK_*).
//  It sits between the instruction memory/data bus and the opcode decoder.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max mem wait cycles before fault (used only with MEM_TIMEOUT_EN)
//  HALT_OPCODE     6'b111111  opcode that stops the sequencer
// PORTS
//  clk           in   1  sole clock, rising edge
//  rst           in   1  synchronous, active-high reset
//  run           in   1  leave IDLE/HALT and start fetching
//  opcode        in   6  IR[15:10], valid from the DECODE cycle onward
//  branch_taken  in   1  flag-condition result for the current branch
//  mem_ready     in   1  memory completes the current request this cycle
//  mem_req       out  1  memory request, held until mem_ready
//  mem_we        out  1  write request (STORE, PUSH)
//  mem_addr_sel  out  2  0=PC, 1=operand (X/Y), 2=SP
//  ir_load       out  1  capture instruction word
//  pc_inc        out  1  PC += 1
//  pc_load       out  1  PC <= branch target
//  sp_inc        out  1  SP += 1 (pop)
//  sp_dec        out  1  SP -= 1 (push)
//  exec_en       out  1  one-cycle qualifier for decoder/ALU/flag update
//  reg_we        out  1  destination register write strobe
//  phase         out  3  current state encoding (debug)
//  halted        out  1  state == HALT
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Outputs are a Moore decode of the state plus a registered class.
//  - Reset: rst sampled high -> state IDLE, class NOP. Every output is 0 in IDLE; phase reads 0.
//  - Transitions:
//    - IDLE -> FETCH when run=1.
//    - HALT -> FETCH when run=1.
//  - FETCH: mem_req=1, mem_addr_sel=0, mem_we=0, held until mem_ready.
//    - In the mem_ready cycle: ir_load=1, pc_inc=1, next state DECODE.
//  - DECODE: latch class from opcode.
//    - Classes: TR 0x00-01, LOAD 0x02, STORE 0x03, PUSH 0x04, POP 0x05, BRA 0x06-0x0C, ALU 0x0D-0x1D, MOV 0x1E, HALT=HALT_OPCODE, others NOP.
//    - HALT -> HALT; every other class -> EXEC.
//  - EXEC: exec_en=1 for exactly one cycle.
//    - BRA: pc_load=branch_taken, except 0x0A, which is unconditional (pc_load=1). Next FETCH.
//    - POP: sp_inc=1 in EXEC. Next MEM.
//    - LOAD/STORE/PUSH: next MEM.
//    - NOP: next FETCH.
//    - Others: next WB.
//  - MEM: mem_req=1 held until mem_ready.
//    - mem_we=1 for STORE/PUSH.
//    - mem_addr_sel=1 for LOAD/STORE, 2 for PUSH/POP.
//    - PUSH: sp_dec=1 in the mem_ready cycle (write at SP, then decrement).
//    - On mem_ready: LOAD/POP -> WB; STORE/PUSH -> FETCH.
//  - WB: reg_we=1 one cycle, then FETCH. CMP (0x14) writes flags only: reg_we=0.
//  - Latency with zero wait states (FETCH answered in its first cycle):
//    - TR/ALU/MOV: 4 cycles.
//    - BRA: 3 cycles.
//    - STORE/PUSH: 4 cycles.
//    - LOAD/POP: 5 cycles.
//  - Each mem_ready wait cycle adds 1. mem_ready outside FETCH/MEM is ignored.
//  - pc_inc and pc_load are never both 1 in one cycle. sp_inc and sp_dec are never both 1.
//  - rst mid-FETCH/MEM: mem_req drops at the next edge; no strobe issued after that edge.
//  - run while busy: ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - Wait counter (8b) cleared on entering FETCH/MEM, increments each cycle mem_ready=0.
//    - Reaching TIMEOUT_CYCLES -> HALT, dropping mem_req, and output fault=1 (sticky, cleared only by rst).
//  MEM_TIMEOUT_EN undefined: no counter, no fault port; FETCH/MEM wait indefinitely.
// STRUCTURE
//  - cpu_pkg:
//    - opcode constants (OP_TR_X..OP_MOV, OP_CMP, OP_JMP)
//    - class enum
//    - state enum
//    - addr_sel constants.
//  - One sub-module, opcode_classifier: combinational opcode -> class; reusable by the decoder.
// TESTING
//  - rst=1 two cycles, then run=1 -> all outputs 0 while reset; FETCH next cycle, mem_req=1, mem_addr_sel=0.
//  - ALU 0x0D, mem_ready immediate -> ir_load/pc_inc c1, exec_en c3, reg_we c4, mem_req again c5.
//  - LOAD 0x02, MEM mem_ready after 3 waits -> mem_req held 4 cycles with sel=1, then reg_we 1 cycle.
//  - PUSH 0x04 then POP 0x05 -> PUSH: mem_we=1, sel=2, sp_dec in ready cycle. POP: sp_inc in EXEC, no mem_we.
//  - BRA 0x06 with branch_taken=0, then 0x0A with taken=0 -> pc_load 0 then 1; no reg_we; CMP 0x14 -> reg_we 0.
//  - HALT_OPCODE, then rst asserted mid-MEM with MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and ready stuck low:
//    - halted=1 after DECODE; run resumes FETCH.
//    - Timeout run: fault=1 and halted=1 after 4 waits.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control path:
// sequencer states, instruction classes, opcode values and address-select codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP   = 4'd0,
    CLS_TR    = 4'd1,
    CLS_LOAD  = 4'd2,
    CLS_STORE = 4'd3,
    CLS_PUSH  = 4'd4,
    CLS_POP   = 4'd5,
    CLS_BRA   = 4'd6,
    CLS_ALU   = 4'd7,
    CLS_MOV   = 4'd8,
    CLS_HALT  = 4'd9
  } class_e;

  localparam logic [5:0] OP_TR_X      = 6'h00;
  localparam logic [5:0] OP_TR_Y      = 6'h01;
  localparam logic [5:0] OP_LOAD      = 6'h02;
  localparam logic [5:0] OP_STORE     = 6'h03;
  localparam logic [5:0] OP_PUSH      = 6'h04;
  localparam logic [5:0] OP_POP       = 6'h05;
  localparam logic [5:0] OP_BRA_FIRST = 6'h06;
  localparam logic [5:0] OP_JMP       = 6'h0A;
  localparam logic [5:0] OP_BRA_LAST  = 6'h0C;
  localparam logic [5:0] OP_ALU_FIRST = 6'h0D;
  localparam logic [5:0] OP_CMP       = 6'h14;
  localparam logic [5:0] OP_ALU_LAST  = 6'h1D;
  localparam logic [5:0] OP_MOV       = 6'h1E;

  localparam logic [1:0] ADDR_SEL_PC      = 2'd0;
  localparam logic [1:0] ADDR_SEL_OPERAND = 2'd1;
  localparam logic [1:0] ADDR_SEL_SP      = 2'd2;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class map, shared by the sequencer and the decoder.
module opcode_classifier
  import cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic [5:0] opcode,
  output logic [3:0] op_class
);

  // HALT_OPCODE is a parameter, so it takes priority over any range it might overlap.
  always_comb begin
    op_class = CLS_NOP;
    if (opcode == HALT_OPCODE)
      op_class = CLS_HALT;
    else if (opcode <= OP_TR_Y)
      op_class = CLS_TR;
    else if (opcode == OP_LOAD)
      op_class = CLS_LOAD;
    else if (opcode == OP_STORE)
      op_class = CLS_STORE;
    else if (opcode == OP_PUSH)
      op_class = CLS_PUSH;
    else if (opcode == OP_POP)
      op_class = CLS_POP;
    else if (opcode >= OP_BRA_FIRST && opcode <= OP_BRA_LAST)
      op_class = CLS_BRA;
    else if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST)
      op_class = CLS_ALU;
    else if (opcode == OP_MOV)
      op_class = CLS_MOV;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the accumulator CPU.
// Define MEM_TIMEOUT_EN to add a memory wait watchdog and the sticky fault output.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [5:0]  HALT_OPCODE    = 6'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       exec_en,
  output logic       reg_we,
  output logic [2:0] phase,
`ifdef MEM_TIMEOUT_EN
  output logic       fault,
`endif
  output logic       halted
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
  end

  state_e     state_q, state_d;
  class_e     class_q, class_d;
  logic       jmp_q, jmp_d;
  logic       cmp_q, cmp_d;
  logic [3:0] decoded_class;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
`endif

  opcode_classifier #(
    .HALT_OPCODE(HALT_OPCODE)
  ) u_classifier (
    .opcode  (opcode),
    .op_class(decoded_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      class_q <= CLS_NOP;
      jmp_q   <= 1'b0;
      cmp_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      jmp_q   <= jmp_d;
      cmp_q   <= cmp_d;
`ifdef MEM_TIMEOUT_EN
      wait_q  <= wait_d;
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    jmp_d        = jmp_q;
    cmp_d        = cmp_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_SEL_PC;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    exec_en      = 1'b0;
    reg_we       = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        class_d = class_e'(decoded_class);
        jmp_d   = (opcode == OP_JMP);
        cmp_d   = (opcode == OP_CMP);
        state_d = (class_e'(decoded_class) == CLS_HALT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        case (class_q)
          CLS_BRA: begin
            pc_load = jmp_q | branch_taken;
            state_d = ST_FETCH;
          end
          CLS_POP: begin
            sp_inc  = 1'b1;
            state_d = ST_MEM;
          end
          CLS_LOAD, CLS_STORE, CLS_PUSH: state_d = ST_MEM;
          CLS_NOP:                       state_d = ST_FETCH;
          default:                       state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_we       = (class_q == CLS_STORE) || (class_q == CLS_PUSH);
        mem_addr_sel = (class_q == CLS_PUSH || class_q == CLS_POP) ? ADDR_SEL_SP
                                                                   : ADDR_SEL_OPERAND;
        if (mem_ready) begin
          sp_dec  = (class_q == CLS_PUSH);
          state_d = (class_q == CLS_LOAD || class_q == CLS_POP) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        reg_we  = ~cmp_q;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MEM_TIMEOUT_EN
    // Any cycle not spent waiting on memory restarts the count, so each FETCH/MEM visit starts at zero.
    wait_d  = 8'd0;
    fault_d = fault_q;
    if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
      if (wait_q == WAIT_LIMIT) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
`endif
  end

  assign phase  = state_q;
  assign halted = (state_q == ST_HALT);
`ifdef MEM_TIMEOUT_EN
  assign fault  = fault_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: each scenario is a per-cycle table of inputs
// and hand-derived phase/strobe values; the timeout scenario needs MEM_TIMEOUT_EN.
module tb_instr_sequencer;

  localparam logic [11:0] MREQ = 12'h800;
  localparam logic [11:0] MWE  = 12'h400;
  localparam logic [11:0] SEL2 = 12'h200;
  localparam logic [11:0] SEL1 = 12'h100;
  localparam logic [11:0] IRL  = 12'h080;
  localparam logic [11:0] PCI  = 12'h040;
  localparam logic [11:0] PCL  = 12'h020;
  localparam logic [11:0] SPI  = 12'h010;
  localparam logic [11:0] SPD  = 12'h008;
  localparam logic [11:0] EXE  = 12'h004;
  localparam logic [11:0] RWE  = 12'h002;
  localparam logic [11:0] HLT  = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 4;
`else
  localparam int unsigned TO_CYCLES = 255;
`endif

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        rdy;
    logic        taken;
    logic [5:0]  op;
    logic [2:0]  ph;
    logic [11:0] outs;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_load, pc_inc, pc_load, sp_inc, sp_dec, exec_en, reg_we, halted;
  logic [1:0] mem_addr_sel;
  logic [2:0] phase;
`ifdef MEM_TIMEOUT_EN
  logic       fault;
`endif
  logic [11:0] outs_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign outs_w = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
                   sp_inc, sp_dec, exec_en, reg_we, halted};

  instr_sequencer #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .HALT_OPCODE   (6'h3F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .opcode      (opcode),
    .branch_taken(branch_taken),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .sp_inc      (sp_inc),
    .sp_dec      (sp_dec),
    .exec_en     (exec_en),
    .reg_we      (reg_we),
    .phase       (phase),
`ifdef MEM_TIMEOUT_EN
    .fault       (fault),
`endif
    .halted      (halted)
  );

  task automatic apply_stimulus(input step_t s);
    rst          = s.rst;
    run          = s.run;
    mem_ready    = s.rdy;
    branch_taken = s.taken;
    opcode       = s.op;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t v [4] = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, NONE},
      '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 3'd0, NONE},
      '{1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 3'd0, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1, MREQ}
    };
    rst = 1'b1;
    next_cycle();
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL reset[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

  task automatic test_alu();
    step_t v [5] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h0D, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 3'd5, RWE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 3'd1, MREQ}
    };
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL alu[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

  // mem_ready is also pulsed in DECODE/EXEC, where it must have no effect.
  task automatic test_load_wait();
    step_t v [9] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 3'd4, MREQ | SEL1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 3'd4, MREQ | SEL1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 3'd4, MREQ | SEL1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 3'd4, MREQ | SEL1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 3'd5, RWE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 3'd1, MREQ}
    };
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL load[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

  task automatic test_push_pop();
    step_t v [11] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h04, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h04, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h04, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h04, 3'd4, MREQ | MWE | SEL2},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h04, 3'd4, MREQ | MWE | SEL2 | SPD},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h05, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h05, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h05, 3'd3, EXE | SPI},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h05, 3'd4, MREQ | SEL2},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h05, 3'd5, RWE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h05, 3'd1, MREQ}
    };
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL push_pop[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

  // Conditional branch not taken, JMP with taken=0, conditional taken, then CMP.
  task automatic test_branch_cmp();
    step_t v [14] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h06, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h06, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h06, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h0A, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h0A, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h0A, 3'd3, EXE | PCL},
      '{1'b0, 1'b0, 1'b1, 1'b1, 6'h07, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b1, 6'h07, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b1, 6'h07, 3'd3, EXE | PCL},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h14, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h14, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h14, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h14, 3'd5, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h14, 3'd1, MREQ}
    };
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL branch_cmp[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

  // HALT then resume; then an unassigned opcode (NOP) with run toggled while busy.
  task automatic test_halt_nop();
    step_t v [9] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3F, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 3'd6, HLT},
      '{1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 3'd6, HLT},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 3'd1, MREQ},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3E, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b1, 1'b0, 1'b0, 6'h3E, 3'd2, NONE},
      '{1'b0, 1'b1, 1'b0, 1'b0, 6'h3E, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3E, 3'd1, MREQ}
    };
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL halt_nop[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

  // STORE held in MEM, reset asserted there; ready after the reset edge must not strobe.
  task automatic test_reset_mid_mem();
    step_t v [8] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h03, 3'd1, MREQ | IRL | PCI},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 3'd2, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 3'd3, EXE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 3'd4, MREQ | MWE | SEL1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 6'h03, 3'd4, MREQ | MWE | SEL1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 6'h03, 3'd0, NONE},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h03, 3'd0, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 3'd0, NONE}
    };
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w} !== {v[i].ph, v[i].outs}) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_mem[%0d] got phase=%0d outs=%b, want phase=%0d outs=%b",
                 i, phase, outs_w, v[i].ph, v[i].outs);
      end
      next_cycle();
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  // From IDLE: four FETCH cycles without ready trip the watchdog (TIMEOUT_CYCLES=4).
  task automatic test_timeout();
    step_t v [8] = '{
      '{1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 3'd0, NONE},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1, MREQ},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1, MREQ},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1, MREQ},
      '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1, MREQ},
      '{1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 3'd6, HLT},
      '{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 3'd1, MREQ | IRL | PCI},
      '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd2, NONE}
    };
    logic fault_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    foreach (v[i]) begin
      apply_stimulus(v[i]);
      n_checks++;
      if ({phase, outs_w, fault} !== {v[i].ph, v[i].outs, fault_exp[i]}) begin
        n_fail++;
        $display("[TB] FAIL timeout[%0d] got phase=%0d outs=%b fault=%b, want phase=%0d outs=%b fault=%b",
                 i, phase, outs_w, fault, v[i].ph, v[i].outs, fault_exp[i]);
      end
      next_cycle();
    end
    n_checks++;
    if ({phase, outs_w, fault} !== {3'd0, NONE, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL timeout_clear got phase=%0d outs=%b fault=%b, want phase=0 outs=0 fault=0",
               phase, outs_w, fault);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_push_pop();
    test_branch_cmp();
    test_halt_nop();
    test_reset_mid_mem();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
